// File: rtl/fcc_rpage_buf.sv
// Read-page buffer: captures every read-data beat from the core and replays it to the host as a valid/ready stream.
// Latency: a beat written into an empty buffer is presented two clocks later (RAM read stage + output register).
// Backpressure: the input can never be stalled; o_rpage_buf_ready gates page starts, and beats arriving while full are dropped and flagged.
module fcc_rpage_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 13,
  parameter int PAGE_WORDS = 4608
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst,
  input  logic                  i_rvalid,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [3:0]            i_ruser,
  input  logic [15:0]           i_rid,
  input  logic                  i_rlast,
  output logic                  o_rpage_buf_ready,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [3:0]            o_m_user,
  output logic [15:0]           o_m_id,
  output logic                  o_m_last,
  output logic [7:0]            o_pages_stored,
  output logic                  o_overflow,
  input  logic                  i_clr_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int EW    = DATA_WIDTH + 21;
  localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W+1)'(DEPTH);
  // Largest occupancy that still leaves room for a whole page.
  localparam logic [ADDR_W:0] RDY_MAX_OCC = (ADDR_W+1)'(DEPTH - PAGE_WORDS);

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   ram_q;
  logic            s1_vld;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] occ;
  logic            in_page;

  logic full, wr_en, xfer, out_take, s1_adv, fetch;

  // Occupancy includes the RAM read stage and the output register, so the
  // RAM itself can never be overrun while occ < DEPTH.
  always_comb begin
    full     = (occ == DEPTH_C);
    wr_en    = i_rvalid && !full;
    xfer     = o_m_valid && i_m_ready;
    out_take = !o_m_valid || i_m_ready;
    s1_adv   = s1_vld && out_take;
    fetch    = (wr_ptr != rd_ptr) && (!s1_vld || s1_adv);
  end

  // Storage array and its registered read port; contents need no reset since
  // the pointers define what is valid.
  always_ff @(posedge usr_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {i_rlast, i_ruser, i_rid, i_rdata};
    if (fetch) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
  end

  // Pointers, pipeline valids, output register and status.
  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      occ               <= '0;
      s1_vld            <= 1'b0;
      in_page           <= 1'b0;
      o_m_valid         <= 1'b0;
      o_m_data          <= '0;
      o_m_user          <= '0;
      o_m_id            <= '0;
      o_m_last          <= 1'b0;
      o_pages_stored    <= '0;
      o_overflow        <= 1'b0;
      o_rpage_buf_ready <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;

      if (fetch)       s1_vld <= 1'b1;
      else if (s1_adv) s1_vld <= 1'b0;

      // Output register only moves when empty or being consumed, which keeps
      // the presented beat stable under a host stall.
      if (out_take) begin
        o_m_valid <= s1_vld;
        if (s1_vld) begin
          o_m_data <= ram_q[DATA_WIDTH-1:0];
          o_m_id   <= ram_q[DATA_WIDTH+15:DATA_WIDTH];
          o_m_user <= ram_q[DATA_WIDTH+19:DATA_WIDTH+16];
          o_m_last <= ram_q[DATA_WIDTH+20];
        end
      end

      if (wr_en && !xfer)      occ <= occ + 1'b1;
      else if (!wr_en && xfer) occ <= occ - 1'b1;

      if ((wr_en && i_rlast) && !(xfer && o_m_last)) begin
        if (o_pages_stored != 8'hFF) o_pages_stored <= o_pages_stored + 8'd1;
      end else if (!(wr_en && i_rlast) && (xfer && o_m_last)) begin
        if (o_pages_stored != 8'h00) o_pages_stored <= o_pages_stored - 8'd1;
      end

      // Dropped beats still advance page tracking so the core stays in step.
      if (i_rvalid) in_page <= !i_rlast;

      if (i_rvalid && full) o_overflow <= 1'b1;
      else if (i_clr_ovf)   o_overflow <= 1'b0;

      o_rpage_buf_ready <= (occ <= RDY_MAX_OCC) && !in_page;
    end
  end

endmodule
